// File: rtl/seven_segment_scan_controller.sv
// Multiplexed hex display driver: scans NUM_DIGITS active-low digits through one
// shared 7-segment decoder, with leading-zero blanking and frame-aligned value updates.
module seven_segment_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    I_CLK,
    input  logic                    I_NRESET,
    input  logic                    I_ENABLE,
    input  logic [4*NUM_DIGITS-1:0] I_VALUE,
    input  logic                    I_LOAD,
    input  logic                    I_BLANK_LEADING,
    output logic [NUM_DIGITS-1:0]   O_DIGIT_SEL,
    output logic [6:0]              O_7_SEGMENT,
    output logic                    O_LOAD_ACK,
    output logic                    O_STATE_DBG
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         disp_q, disp_d;
    logic [VW-1:0]         pend_buf_q, pend_buf_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [6:0]            seg_q, seg_d;
    logic                  ack_q, ack_d;

    logic                  tick;
    logic                  scan_wrap;
    logic                  commit;
    logic [3:0]            nib;
    logic                  blank_sel;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic [6:0]            dec_seg;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0011000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // I_LOAD is a single-cycle strobe with no back-pressure; O_LOAD_ACK pulses once per commit.
    always_comb begin
        tick      = (state_q == SCAN) && (presc_q == PRESC_LAST);
        scan_wrap = (state_q == SCAN) && I_ENABLE && tick && (idx_q == IDX_LAST);
        commit    = pend_q && ((state_q == IDLE) || scan_wrap);
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                presc_d = '0;
                idx_d   = '0;
                if (I_ENABLE) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!I_ENABLE) begin
                    state_d = IDLE;
                    presc_d = '0;
                    idx_d   = '0;
                end else if (tick) begin
                    presc_d = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        disp_d     = commit ? pend_buf_q : disp_q;
        pend_buf_d = pend_buf_q;
        pend_d     = pend_q;
        ack_d      = commit;
        if (I_LOAD) begin
            pend_buf_d = I_VALUE;
            pend_d     = 1'b1;
        end else if (commit) begin
            pend_d = 1'b0;
        end
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        zero_above = 1'b1;
        lead_zero  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above   = zero_above & (disp_d[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_above;
        end
    end

    always_comb begin
        nib       = 4'h0;
        blank_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                nib       = disp_d[4*i +: 4];
                blank_sel = lead_zero[i];
            end
        end
    end

    assign dec_seg = hex_to_seg(nib);

    // Outputs are built from next-state values so select and segments update together.
    always_comb begin
        sel_d = '1;
        seg_d = 7'b1111111;
        if (state_d == SCAN) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                sel_d[i] = (idx_d != IW'(i));
            end
            seg_d = (I_BLANK_LEADING && blank_sel) ? 7'b1111111 : dec_seg;
        end
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            pend_buf_q <= '0;
            pend_q     <= 1'b0;
            sel_q      <= '1;
            seg_q      <= 7'b1111111;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            pend_buf_q <= pend_buf_d;
            pend_q     <= pend_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            ack_q      <= ack_d;
        end
    end

    assign O_DIGIT_SEL = sel_q;
    assign O_7_SEGMENT = seg_q;
    assign O_LOAD_ACK  = ack_q;
    assign O_STATE_DBG = state_q;

endmodule

// File: doc/seven_segment_scan_controller.md
SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed display digits (range 2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles per digit dwell (minimum 2).
REQ-003 SHALL have I_CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have I_NRESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have I_ENABLE, input, 1 bit: high scans the display; low blanks it.
REQ-006 SHALL have I_VALUE, input, 4*NUM_DIGITS bits: hex nibbles, with bits [3:0] as digit 0 (least significant).
REQ-007 SHALL have I_LOAD, input, 1 bit: one-cycle strobe that captures I_VALUE as a pending update.
REQ-008 SHALL have I_BLANK_LEADING, input, 1 bit: high enables leading-zero suppression.
REQ-009 SHALL have O_DIGIT_SEL, output, NUM_DIGITS bits: active-low one-hot digit enable.
REQ-010 SHALL have O_7_SEGMENT, output, 7 bits: active-low segments, with the MSB to LSB as segments 0123456.
REQ-011 SHALL have O_LOAD_ACK, output, 1 bit: one-cycle pulse when a pending update is committed.

Function
REQ-012 SHALL contain exactly one hex-to-7-segment decoder, shared across all digits by time multiplexing.
REQ-013 SHALL implement the FSM states IDLE and SCAN: IDLE->SCAN when I_ENABLE=1; SCAN->IDLE when I_ENABLE=0, on the same edge.
REQ-014 In IDLE, SHALL drive O_DIGIT_SEL all ones and O_7_SEGMENT=7'b1111111, and hold the prescaler and digit index at 0.
REQ-015 On the IDLE->SCAN edge, SHALL drive digit 0 (O_DIGIT_SEL bit 0 low) and start the prescaler counting from 0.
REQ-016 In SCAN, the prescaler SHALL count 0..REFRESH_DIV-1 and raise an internal tick when it equals REFRESH_DIV-1, then wrap to 0.
REQ-017 On a tick, the digit index SHALL increment, wrapping from NUM_DIGITS-1 to 0; each digit therefore dwells exactly REFRESH_DIV cycles.
REQ-018 O_DIGIT_SEL and O_7_SEGMENT SHALL be registered and SHALL change on the same edge, so they never show a mismatched digit and segment pattern.
REQ-019 Segment codes SHALL be 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0011000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110.
REQ-020 With I_BLANK_LEADING=1, digit i (i>0) SHALL output 7'b1111111 when digit i and all higher digits of the display register are 0; digit 0 SHALL never be blanked.
REQ-021 Blanking SHALL affect O_7_SEGMENT only; O_DIGIT_SEL SHALL continue scanning.
REQ-022 On I_LOAD=1, I_VALUE SHALL be captured into a pending buffer and the pending flag set.
REQ-023 In SCAN, a pending update SHALL commit to the display register only on the tick that wraps the digit index to 0, so no frame mixes old and new values.
REQ-024 In IDLE, a pending update SHALL commit on the next edge.
REQ-025 O_LOAD_ACK SHALL be high for exactly the one cycle after each commit.
REQ-026 Multiple I_LOAD strobes before a commit SHALL overwrite the pending buffer (latest value wins) and SHALL produce a single O_LOAD_ACK.
REQ-027 If I_LOAD coincides with a commit edge, the previously pending value SHALL commit; the new value SHALL be captured and remain pending for the next frame boundary.
REQ-028 When I_ENABLE falls mid-frame, scanning SHALL stop immediately and any pending value SHALL commit per REQ-024.

Reset
REQ-029 While I_NRESET=0, the block SHALL be in state IDLE with O_DIGIT_SEL all ones, O_7_SEGMENT=7'b1111111, O_LOAD_ACK=0, display register 0, pending buffer 0, pending flag 0, prescaler 0 and digit index 0.
REQ-030 Reset assertion mid-scan or mid-pending SHALL discard the pending value with no O_LOAD_ACK; after release the block SHALL resume per REQ-013.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-031 Bench SHALL cover: load 16'h12AF with I_ENABLE=0, then enable -> O_LOAD_ACK one cycle after the load; O_DIGIT_SEL sequence 1110,1101,1011,0111, 4 cycles each; segments 0001110,0001000,0100100,1111001.
REQ-032 Bench SHALL cover: I_BLANK_LEADING=1 with value 16'h0050 -> digits 3 and 2 output 1111111, digit 1 outputs 0010010, digit 0 outputs 1000000; with value 16'h0000, only digit 0 is lit, showing 1000000.
REQ-033 Bench SHALL cover: loads of 16'h1111 then 16'h2222 during the same frame while scanning -> a single O_LOAD_ACK at the wrap to digit 0; no frame shows digit 1111 mixed with 2222.
REQ-034 Bench SHALL cover: I_LOAD of 16'h3333 on the exact commit edge of a pending 16'h2222 -> 2222 is displayed for one full frame, then 3333; two O_LOAD_ACK pulses, one frame apart.
REQ-035 Bench SHALL cover: I_ENABLE dropped while digit 2 is active -> all outputs are 1 on the next edge; re-enable -> digit 0 is selected first.
REQ-036 Bench SHALL cover: I_NRESET pulsed low asynchronously with a load pending -> outputs are all 1 immediately; no O_LOAD_ACK; the display register reads 0.
